// File: rtl/ysyx_23060337_pipe_skid.sv
//==============================================================================
// Module   : ysyx_23060337_pipe_skid
// Purpose  : two-entry valid/ready skid buffer between NPC stages, with flush.
//            Optional stall counter: define YSYX_23060337_PIPE_PERF_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

// Write-enabled flop with synchronous active-high reset.
module ysyx_23060337_Reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  always_ff @(posedge clk) begin
    if (rst)        o_dout <= RESET_VAL;
    else if (i_wen) o_dout <= i_din;
  end
endmodule

module ysyx_23060337_pipe_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef YSYX_23060337_PIPE_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_wen;
  logic             w_skid_wen;
  logic [WIDTH-1:0] w_main_din;

  // Handshake outputs decode registered state only: no out_ready->in_ready path.
  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // A flush voids any handshake in the same cycle, so no register is written.
  always_comb begin
    w_main_wen = 1'b0;
    w_skid_wen = 1'b0;
    w_main_din = in_data;
    if (!flush) begin
      unique case (r_state)
        S_EMPTY: w_main_wen = w_in_fire;
        S_BUSY: begin
          if (w_in_fire && w_out_fire) w_main_wen = 1'b1;
          else if (w_in_fire)          w_skid_wen = 1'b1;
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_main_wen = 1'b1;
            w_main_din = r_skid;
          end
        end
        default: ;
      endcase
    end
  end

  ysyx_23060337_Reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_main_wen),
    .i_din  (w_main_din),
    .o_dout (r_main)
  );

  ysyx_23060337_Reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_skid_wen),
    .i_din  (in_data),
    .o_dout (r_skid)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_in_fire) r_state <= S_BUSY;
        S_BUSY: begin
          if (w_in_fire && !w_out_fire)      r_state <= S_FULL;
          else if (!w_in_fire && w_out_fire) r_state <= S_EMPTY;
        end
        S_FULL:  if (w_out_fire) r_state <= S_BUSY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef YSYX_23060337_PIPE_PERF_EN
  // Counts downstream backpressure cycles; survives flush, wraps naturally.
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst)                         r_stall_cnt <= 32'd0;
    else if (out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060337_pipe_skid.sv
//==============================================================================
// Module   : tb_ysyx_23060337_pipe_skid
// Purpose  : directed self-checking bench for the pipeline skid buffer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ysyx_23060337_pipe_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef YSYX_23060337_PIPE_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060337_pipe_skid #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef YSYX_23060337_PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_main",      out_data,           32'h0);
    tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Single beat, one-cycle latency
    out_ready = 1'b1;
    send(32'hA5A5_A5A5);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data",  out_data,           32'hA5A5_A5A5);
    in_valid = 1'b0;
    tick();
    check("single_drain", {31'd0, out_valid}, 32'd0);

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      send(32'(i));
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data",  out_data,           32'(i));
      check("stream_ready", {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: two beats absorbed, third held off
    out_ready = 1'b0;
    send(32'h11);
    check("bp_ready_busy", {31'd0, in_ready}, 32'd1);
    check("bp_data_11",    out_data,          32'h11);
    send(32'h22);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_hold_11",    out_data,          32'h11);
    send(32'h33);
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    check("bp_still_11",   out_data,          32'h11);
    out_ready = 1'b1;
    tick();
    check("bp_rel_ready",  {31'd0, in_ready}, 32'd1);
    check("bp_rel_22",     out_data,          32'h22);
    tick();
    check("bp_rel_33",     out_data,          32'h33);
    in_valid = 1'b0;
    tick();
    check("bp_drain",      {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a pending beat
    out_ready = 1'b0;
    send(32'h66);
    send(32'h77);
    check("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    send(32'h44);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    tick();
    check("fl_no_44", {31'd0, out_valid}, 32'd0);

    // Flush in BUSY voids an accepted handshake
    out_ready = 1'b0;
    send(32'h88);
    flush = 1'b1;
    send(32'h44);
    flush = 1'b0; in_valid = 1'b0;
    check("flb_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("flb_still_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(32'h99);
    check("flb_next_valid", {31'd0, out_valid}, 32'd1);
    check("flb_next_data",  out_data,           32'h99);
    in_valid = 1'b0;
    tick();

    // Reset while FULL
    out_ready = 1'b0;
    send(32'hAA);
    send(32'hBB);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_out_valid", {31'd0, out_valid}, 32'd0);
    check("rf_in_ready",  {31'd0, in_ready},  32'd1);
    check("rf_main",      out_data,           32'h0);
`ifdef YSYX_23060337_PIPE_PERF_EN
    check("rf_stall_cnt", stall_cnt, 32'd0);
`endif
    out_ready = 1'b1;
    send(32'h55);
    check("rf_beat_valid", {31'd0, out_valid}, 32'd1);
    check("rf_beat_data",  out_data,           32'h55);
    in_valid = 1'b0;
    tick();
    check("rf_drain", {31'd0, out_valid}, 32'd0);

`ifdef YSYX_23060337_PIPE_PERF_EN
    // Five stall cycles, then a flush must not clear the counter
    out_ready = 1'b0;
    send(32'h12);
    in_valid = 1'b0;
    check("perf_zero", stall_cnt, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("perf_five", stall_cnt, 32'd5);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_flush_keep", stall_cnt, 32'd5);
    tick();
    check("perf_idle_keep", stall_cnt, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
